// File: rtl/tlul_err_rsp_gen_if.sv
// TL-UL A/D channel bundle between a host (master) and the error responder (slave).
// Signal suffixes are named from the responder's point of view.
interface tlul_err_rsp_gen_if #(
  parameter int IW  = 8,
  parameter int SZW = 2,
  parameter int DW  = 32
);
  logic           a_valid_i;
  logic [2:0]     a_opcode_i;
  logic [SZW-1:0] a_size_i;
  logic [IW-1:0]  a_source_i;
  logic           a_ready_o;
  logic           d_valid_o;
  logic [2:0]     d_opcode_o;
  logic [2:0]     d_param_o;
  logic [SZW-1:0] d_size_o;
  logic [IW-1:0]  d_source_o;
  logic           d_sink_o;
  logic [DW-1:0]  d_data_o;
  logic           d_error_o;
  logic           d_ready_i;

  modport slave (
    input  a_valid_i, a_opcode_i, a_size_i, a_source_i, d_ready_i,
    output a_ready_o, d_valid_o, d_opcode_o, d_param_o, d_size_o,
           d_source_o, d_sink_o, d_data_o, d_error_o
  );

  modport master (
    output a_valid_i, a_opcode_i, a_size_i, a_source_i, d_ready_i,
    input  a_ready_o, d_valid_o, d_opcode_o, d_param_o, d_size_o,
           d_source_o, d_sink_o, d_data_o, d_error_o
  );
endinterface

// File: rtl/tlul_err_rsp_gen.sv
// Absorbs A-channel requests flagged as erroneous and answers each, in order,
// with a D-channel error response through a small circular response queue.
module tlul_err_rsp_gen #(
  parameter int IW       = 8,
  parameter int SZW      = 2,
  parameter int DW       = 32,
  parameter int RspDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tlul_err_rsp_gen_if.slave    bus,
  output logic [7:0]           err_cnt_o
);

  localparam int PW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int CW = $clog2(RspDepth + 1);
  localparam logic [CW-1:0] DepthC   = CW'(RspDepth);
  localparam logic [PW-1:0] LastPtrC = PW'(RspDepth - 1);

  if (RspDepth < 1 || RspDepth > 8) begin : g_depth_check
    $error("RspDepth must be in 1..8");
  end

  logic           rsp_op_q  [RspDepth];
  logic           rsp_op_d  [RspDepth];
  logic [SZW-1:0] size_q    [RspDepth];
  logic [SZW-1:0] size_d    [RspDepth];
  logic [IW-1:0]  source_q  [RspDepth];
  logic [IW-1:0]  source_d  [RspDepth];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     err_cnt_q, err_cnt_d;

  logic a_ready;
  logic d_valid;
  logic enq;
  logic deq;
  logic head_op;

  assign a_ready = (count_q != DepthC);
  assign d_valid = (count_q != '0);
  assign enq     = bus.a_valid_i & a_ready;
  assign deq     = d_valid & bus.d_ready_i;
  assign head_op = rsp_op_q[rd_ptr_q];

  always_comb begin
    rsp_op_d  = rsp_op_q;
    size_d    = size_q;
    source_d  = source_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;

    // Only Get expects data back; every other opcode, legal or not, gets a plain ack.
    if (enq) begin
      rsp_op_d[wr_ptr_q] = (bus.a_opcode_i == 3'd4);
      size_d[wr_ptr_q]   = bus.a_size_i;
      source_d[wr_ptr_q] = bus.a_source_i;
      wr_ptr_d           = (wr_ptr_q == LastPtrC) ? '0 : wr_ptr_q + PW'(1);
    end

    if (deq) begin
      rd_ptr_d = (rd_ptr_q == LastPtrC) ? '0 : rd_ptr_q + PW'(1);
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RspDepth; i++) begin
        rsp_op_q[i] <= 1'b0;
        size_q[i]   <= '0;
        source_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      rsp_op_q  <= rsp_op_d;
      size_q    <= size_d;
      source_q  <= source_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // D fields come straight from the registered head entry and are forced to zero when empty.
  assign bus.a_ready_o  = a_ready;
  assign bus.d_valid_o  = d_valid;
  assign bus.d_opcode_o = d_valid ? {2'b00, head_op} : 3'd0;
  assign bus.d_param_o  = 3'd0;
  assign bus.d_size_o   = d_valid ? size_q[rd_ptr_q] : '0;
  assign bus.d_source_o = d_valid ? source_q[rd_ptr_q] : '0;
  assign bus.d_sink_o   = 1'b0;
  assign bus.d_data_o   = (d_valid && head_op) ? '1 : '0;
  assign bus.d_error_o  = d_valid;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_tlul_err_rsp_gen.sv
// Self-checking bench: hand-computed vector table for the directed scenarios, then
// randomized traffic checked against a queue-based reference model.
module tb_tlul_err_rsp_gen;

  localparam int IW    = 8;
  localparam int SZW   = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic       clk;
  logic       rst;
  logic [7:0] err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  tlul_err_rsp_gen_if #(.IW(IW), .SZW(SZW), .DW(DW)) bus ();

  tlul_err_rsp_gen #(.IW(IW), .SZW(SZW), .DW(DW), .RspDepth(DEPTH)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .err_cnt_o (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a_valid;
    logic [2:0] op;
    logic [1:0] size;
    logic [7:0] src;
    logic       d_ready;
    logic       exp_a_ready;
    logic       exp_d_valid;
    logic [2:0] exp_op;
    logic [1:0] exp_size;
    logic [7:0] exp_src;
    logic [31:0] exp_data;
    logic [7:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [1:0] size;
    logic [7:0] src;
  } ent_t;

  ent_t mq[$];
  int   m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] sz,
                       input logic [7:0] src, input logic dr);
    bus.a_valid_i  = v;
    bus.a_opcode_i = op;
    bus.a_size_i   = sz;
    bus.a_source_i = src;
    bus.d_ready_i  = dr;
  endtask

  // Compare every DUT output against the reference model's view of the queue.
  task automatic check_output();
    ent_t head;
    logic exp_valid;
    head      = '{op: 3'd0, size: 2'd0, src: 8'd0};
    exp_valid = (mq.size() != 0);
    if (exp_valid) head = mq[0];
    check("a_ready",  {63'd0, bus.a_ready_o}, {63'd0, (mq.size() < DEPTH)});
    check("d_valid",  {63'd0, bus.d_valid_o}, {63'd0, exp_valid});
    check("d_error",  {63'd0, bus.d_error_o}, {63'd0, exp_valid});
    check("d_opcode", {61'd0, bus.d_opcode_o}, {61'd0, head.op});
    check("d_size",   {62'd0, bus.d_size_o}, {62'd0, head.size});
    check("d_source", {56'd0, bus.d_source_o}, {56'd0, head.src});
    check("d_data",   {32'd0, bus.d_data_o},
          (exp_valid && head.op == 3'd1) ? 64'hFFFF_FFFF : 64'd0);
    check("d_param",  {61'd0, bus.d_param_o}, 64'd0);
    check("d_sink",   {63'd0, bus.d_sink_o}, 64'd0);
    check("err_cnt",  {56'd0, err_cnt}, (m_err > 255) ? 64'd255 : 64'(m_err));
  endtask

  // One clock of traffic: outputs are checked before the edge, the model advances with it.
  task automatic apply_stimulus(input logic v, input logic [2:0] op, input logic [1:0] sz,
                                input logic [7:0] src, input logic dr);
    logic accept, pop;
    ent_t e;
    drive(v, op, sz, src, dr);
    #1;
    check_output();
    accept = v && (mq.size() < DEPTH);
    pop    = dr && (mq.size() != 0);
    e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    e.size = sz;
    e.src  = src;
    @(posedge clk);
    if (pop) begin
      void'(mq.pop_front());
      m_err++;
    end
    if (accept) mq.push_back(e);
    @(negedge clk);
  endtask

  // Reset asserted away from any clock edge; its effect must be visible immediately.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    check("rst_a_ready", {63'd0, bus.a_ready_o}, 64'd1);
    check("rst_d_valid", {63'd0, bus.d_valid_o}, 64'd0);
    check("rst_d_error", {63'd0, bus.d_error_o}, 64'd0);
    check("rst_d_data",  {32'd0, bus.d_data_o}, 64'd0);
    check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    mq.delete();
    m_err = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 2'd0, 8'd0, 1'b0);
    m_err = 0;

    //        v  op    sz    src    dr  ard dv op    sz    src    data          cnt
    vecs[0]  = '{1, 3'd4, 2'd2, 8'h5A, 1, 1, 1, 3'd1, 2'd2, 8'h5A, 32'hFFFF_FFFF, 8'd0};
    vecs[1]  = '{0, 3'd0, 2'd0, 8'h00, 1, 1, 0, 3'd0, 2'd0, 8'h00, 32'h0,         8'd1};
    vecs[2]  = '{1, 3'd0, 2'd0, 8'h11, 1, 1, 1, 3'd0, 2'd0, 8'h11, 32'h0,         8'd1};
    vecs[3]  = '{1, 3'd1, 2'd1, 8'h22, 1, 1, 1, 3'd0, 2'd1, 8'h22, 32'h0,         8'd2};
    vecs[4]  = '{1, 3'd6, 2'd3, 8'h33, 1, 1, 1, 3'd0, 2'd3, 8'h33, 32'h0,         8'd3};
    vecs[5]  = '{0, 3'd0, 2'd0, 8'h00, 1, 1, 0, 3'd0, 2'd0, 8'h00, 32'h0,         8'd4};
    vecs[6]  = '{1, 3'd4, 2'd2, 8'hA1, 0, 1, 1, 3'd1, 2'd2, 8'hA1, 32'hFFFF_FFFF, 8'd4};
    vecs[7]  = '{1, 3'd0, 2'd1, 8'hB2, 0, 0, 1, 3'd1, 2'd2, 8'hA1, 32'hFFFF_FFFF, 8'd4};
    vecs[8]  = '{1, 3'd4, 2'd0, 8'hC3, 0, 0, 1, 3'd1, 2'd2, 8'hA1, 32'hFFFF_FFFF, 8'd4};
    vecs[9]  = '{1, 3'd4, 2'd0, 8'hC3, 1, 1, 1, 3'd0, 2'd1, 8'hB2, 32'h0,         8'd5};
    vecs[10] = '{1, 3'd4, 2'd0, 8'hC3, 0, 0, 1, 3'd0, 2'd1, 8'hB2, 32'h0,         8'd5};
    vecs[11] = '{0, 3'd0, 2'd0, 8'h00, 1, 1, 1, 3'd1, 2'd0, 8'hC3, 32'hFFFF_FFFF, 8'd6};
    vecs[12] = '{0, 3'd0, 2'd0, 8'h00, 1, 1, 0, 3'd0, 2'd0, 8'h00, 32'h0,         8'd7};

    #2;
    check("init_a_ready", {63'd0, bus.a_ready_o}, 64'd1);
    check("init_d_valid", {63'd0, bus.d_valid_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1'b0, 3'd0, 2'd0, 8'd0, 1'b1);
    apply_stimulus(1'b0, 3'd0, 2'd0, 8'd0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].a_valid, vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].d_ready);
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("v%0d_a_ready", i), {63'd0, bus.a_ready_o}, {63'd0, vecs[i].exp_a_ready});
      check($sformatf("v%0d_d_valid", i), {63'd0, bus.d_valid_o}, {63'd0, vecs[i].exp_d_valid});
      check($sformatf("v%0d_d_error", i), {63'd0, bus.d_error_o}, {63'd0, vecs[i].exp_d_valid});
      check($sformatf("v%0d_d_opcode", i), {61'd0, bus.d_opcode_o}, {61'd0, vecs[i].exp_op});
      check($sformatf("v%0d_d_size", i), {62'd0, bus.d_size_o}, {62'd0, vecs[i].exp_size});
      check($sformatf("v%0d_d_source", i), {56'd0, bus.d_source_o}, {56'd0, vecs[i].exp_src});
      check($sformatf("v%0d_d_data", i), {32'd0, bus.d_data_o}, {32'd0, vecs[i].exp_data});
      check($sformatf("v%0d_err_cnt", i), {56'd0, err_cnt}, {56'd0, vecs[i].exp_cnt});
    end

    // Reset, then streaming: one response per cycle, the queue never holds more than one.
    async_reset();
    apply_stimulus(1'b0, 3'd0, 2'd0, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      check("stream_a_ready", {63'd0, bus.a_ready_o}, 64'd1);
      apply_stimulus(1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'(i + 1), 1'b1);
    end
    apply_stimulus(1'b0, 3'd0, 2'd0, 8'd0, 1'b1);
    check("stream_err_cnt", {56'd0, err_cnt}, 64'd20);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom), 1'b1);
    end
    apply_stimulus(1'b0, 3'd0, 2'd0, 8'd0, 1'b1);
    check("sat_err_cnt", {56'd0, err_cnt}, 64'd255);

    // Two entries queued under backpressure, then a reset must discard them.
    apply_stimulus(1'b1, 3'd4, 2'd1, 8'h77, 1'b0);
    apply_stimulus(1'b1, 3'd0, 2'd2, 8'h88, 1'b0);
    check("full_a_ready", {63'd0, bus.a_ready_o}, 64'd0);
    drive(1'b0, 3'd0, 2'd0, 8'd0, 1'b0);
    async_reset();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, 3'd0, 2'd0, 8'd0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
